// File: rtl/encoder_sample_scheduler.sv
// Periodic snapshot scheduler for a bank of encoder counters: a free timer triggers a
// channel-by-channel sweep into a back buffer, committed atomically to a host-readable front buffer.
// Optional build macro ENC_SCHED_CLEAR_EN: capture raw counts and strobe cnt_clr instead of computing deltas.
module encoder_sample_scheduler #(
    parameter int NUM_ENC      = 5,
    parameter int COUNT_WIDTH  = 15,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [PERIOD_WIDTH-1:0]        period,
    input  logic [NUM_ENC*COUNT_WIDTH-1:0] counts,
    output logic [NUM_ENC-1:0]             cnt_clr,
    input  logic                           rd_req,
    input  logic [2:0]                     rd_sel,
    output logic [COUNT_WIDTH-1:0]         rd_data,
    output logic                           rd_ack,
    output logic                           sample_done,
    output logic                           overrun,
    input  logic                           ovr_clr
);

    localparam int IDX_W = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENC - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SWEEP  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]              state_r;
    logic [1:0]              state_next_s;
    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_next_s;
    logic [PERIOD_WIDTH-1:0] timer_r;
    logic                    tick_s;
    logic [COUNT_WIDTH-1:0]  back_r  [NUM_ENC];
    logic [COUNT_WIDTH-1:0]  front_r [NUM_ENC];
    logic [COUNT_WIDTH-1:0]  rd_val_s;
    logic [COUNT_WIDTH-1:0]  rd_data_r;
    logic                    rd_ack_r;
    logic                    sample_done_r;
    logic                    overrun_r;

    assign tick_s = (period != '0) && (timer_r == (period - PERIOD_WIDTH'(1)));

    // Free-running sample timer; out-of-range values (period shrunk) wrap without a tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r <= '0;
        end else if (period == '0) begin
            timer_r <= '0;
        end else if (timer_r >= (period - PERIOD_WIDTH'(1))) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + PERIOD_WIDTH'(1);
        end
    end

    // Sweep sequencer next-state logic
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            IDLE: begin
                idx_next_s = '0;
                if (tick_s) begin
                    state_next_s = SWEEP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SWEEP: begin
                if (idx_r == LAST_IDX) begin
                    state_next_s = COMMIT;
                    idx_next_s   = '0;
                end else begin
                    state_next_s = SWEEP;
                    idx_next_s   = idx_r + IDX_W'(1);
                end
            end
            COMMIT: begin
                state_next_s = IDLE;
                idx_next_s   = '0;
            end
            default: begin
                state_next_s = IDLE;
                idx_next_s   = '0;
            end
        endcase
    end

    // Sequencer state and the commit strobe, timed to coincide with the COMMIT cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            idx_r         <= '0;
            sample_done_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            idx_r         <= idx_next_s;
            sample_done_r <= (state_next_s == COMMIT);
        end
    end

    // A tick that lands outside IDLE is dropped; the set wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_r <= 1'b0;
        end else if (tick_s && (state_r != IDLE)) begin
            overrun_r <= 1'b1;
        end else if (ovr_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

`ifdef ENC_SCHED_CLEAR_EN
    logic [NUM_ENC-1:0] cnt_clr_r;

    function automatic logic [NUM_ENC-1:0] chan_onehot(input logic [IDX_W-1:0] idx);
        chan_onehot = NUM_ENC'(1) << idx;
    endfunction

    // Clear strobe lines up with the cycle in which its channel is captured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_clr_r <= '0;
        end else if (state_next_s == SWEEP) begin
            cnt_clr_r <= chan_onehot(idx_next_s);
        end else begin
            cnt_clr_r <= '0;
        end
    end

    assign cnt_clr = cnt_clr_r;

    // Raw capture into the back buffer, atomic copy to the front buffer on commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENC; i++) begin
                back_r[i]  <= '0;
                front_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENC; i++) begin
                if ((state_r == SWEEP) && (idx_r == IDX_W'(i))) begin
                    back_r[i] <= counts[i*COUNT_WIDTH +: COUNT_WIDTH];
                end
                if (state_r == COMMIT) begin
                    front_r[i] <= back_r[i];
                end
            end
        end
    end
`else
    logic [COUNT_WIDTH-1:0] prev_r [NUM_ENC];

    assign cnt_clr = '0;

    // Delta capture (wraps modulo 2^COUNT_WIDTH), atomic copy to the front buffer on commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENC; i++) begin
                prev_r[i]  <= '0;
                back_r[i]  <= '0;
                front_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENC; i++) begin
                if ((state_r == SWEEP) && (idx_r == IDX_W'(i))) begin
                    back_r[i] <= counts[i*COUNT_WIDTH +: COUNT_WIDTH] - prev_r[i];
                    prev_r[i] <= counts[i*COUNT_WIDTH +: COUNT_WIDTH];
                end
                if (state_r == COMMIT) begin
                    front_r[i] <= back_r[i];
                end
            end
        end
    end
`endif

    // Host read mux; unpopulated channel indices read as zero
    always_comb begin
        rd_val_s = '0;
        for (int i = 0; i < NUM_ENC; i++) begin
            rd_val_s = (rd_sel == 3'(i)) ? front_r[i] : rd_val_s;
        end
    end

    // Read response one cycle after the request; data holds between acks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ack_r  <= 1'b0;
            rd_data_r <= '0;
        end else if (rd_req) begin
            rd_ack_r  <= 1'b1;
            rd_data_r <= rd_val_s;
        end else begin
            rd_ack_r  <= 1'b0;
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data     = rd_data_r;
    assign rd_ack      = rd_ack_r;
    assign sample_done = sample_done_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_encoder_sample_scheduler.sv
// Self-checking bench for encoder_sample_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a cycle-offset reference model of the sampling schedule.
module tb_encoder_sample_scheduler;

    localparam int N  = 5;
    localparam int CW = 15;
    localparam int PW = 16;
`ifdef ENC_SCHED_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] period;
    logic [N*CW-1:0] counts;
    logic [N-1:0]  cnt_clr;
    logic          rd_req;
    logic [2:0]    rd_sel;
    logic [CW-1:0] rd_data;
    logic          rd_ack;
    logic          sample_done;
    logic          overrun;
    logic          ovr_clr;

    int vectors     = 0;
    int miscompares = 0;

    encoder_sample_scheduler dut (
        .clk(clk), .reset(rst_n), .period(period), .counts(counts), .cnt_clr(cnt_clr),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .rd_ack(rd_ack),
        .sample_done(sample_done), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the sweep is tracked as an offset k from the accepted tick cycle
    // (k = 1..N processes channel k-1, k = N+1 commits).
    int            m_timer, m_cyc, m_start, m_phase, mk, mch;
    bit            mtick, mact;
    logic [CW-1:0] mcur;
    logic [CW-1:0] m_prev [N];
    logic [CW-1:0] m_back [N];
    logic [CW-1:0] m_front[N];
    logic          exp_done, exp_ovr, exp_ack;
    logic [CW-1:0] exp_data;
    logic [N-1:0]  exp_clr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_timer = 0; m_cyc = 0; m_start = -1000; m_phase = -1;
            for (int i = 0; i < N; i++) begin
                m_prev[i] = '0; m_back[i] = '0; m_front[i] = '0;
            end
            exp_done = 1'b0; exp_ovr = 1'b0; exp_ack = 1'b0; exp_data = '0; exp_clr = '0;
        end else begin
            mtick = (period != '0) && (m_timer == int'(period) - 1);
            mk    = m_cyc - m_start;
            mact  = (mk >= 1) && (mk <= N + 1);
            exp_ack = rd_req;
            if (rd_req) begin
                if (int'(rd_sel) < N) exp_data = m_front[rd_sel];
                else exp_data = '0;
            end
            if (mact && mk <= N) begin
                mch  = mk - 1;
                mcur = counts[mch*CW +: CW];
                m_back[mch] = (CLR != 0) ? mcur : mcur - m_prev[mch];
                m_prev[mch] = mcur;
            end
            if (mact && mk == N + 1) begin
                for (int i = 0; i < N; i++) m_front[i] = m_back[i];
            end
            if (mtick && mact) exp_ovr = 1'b1;
            else if (ovr_clr) exp_ovr = 1'b0;
            if (mtick && !mact) m_start = m_cyc;
            if (period == '0) m_timer = 0;
            else if (m_timer >= int'(period) - 1) m_timer = 0;
            else m_timer = m_timer + 1;
            m_cyc   = m_cyc + 1;
            mk      = m_cyc - m_start;
            m_phase = mk;
            exp_done = (mk == N + 1);
            if (CLR != 0 && mk >= 1 && mk <= N) exp_clr = N'(1) << (mk - 1);
            else exp_clr = '0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_count(input int ch, input int v);
        counts[ch*CW +: CW] = CW'(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sample_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_read(input int sel, output logic ack, output logic [CW-1:0] data);
        rd_req = 1'b1;
        rd_sel = 3'(sel);
        @(negedge clk);
        ack    = rd_ack;
        data   = rd_data;
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; period = '0; counts = '0; rd_req = 1'b0; rd_sel = '0; ovr_clr = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({sample_done, overrun, rd_ack, rd_data, cnt_clr} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got done=%b ovr=%b ack=%b data=%h clr=%b exp all 0",
                     sample_done, overrun, rd_ack, rd_data, cnt_clr);
        end
    endtask

    task automatic test_basic();
        int first;
        bit seen;
        logic ack;
        logic [CW-1:0] data;
        logic [CW-1:0] want;
        period = PW'(20);
        for (int i = 0; i < N; i++) set_count(i, 10 * (i + 1));
        do_reset();
        first = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            vectors++;
            if ({sample_done, overrun, rd_ack, rd_data, cnt_clr} !== {exp_done, exp_ovr, exp_ack, exp_data, exp_clr}) begin
                miscompares++;
                $display("FAIL basic_cycle n=%0d got done=%b ovr=%b ack=%b data=%h clr=%b exp done=%b ovr=%b ack=%b data=%h clr=%b",
                         n, sample_done, overrun, rd_ack, rd_data, cnt_clr, exp_done, exp_ovr, exp_ack, exp_data, exp_clr);
            end
            if (sample_done === 1'b1) begin
                first = n;
                break;
            end
        end
        vectors++;
        if (first != 20 + N) begin
            miscompares++;
            $display("FAIL basic_first_sample got cycle %0d exp %0d", first, 20 + N);
        end
        @(negedge clk);
        rd_req = 1'b1;
        for (int i = 0; i < N; i++) begin
            rd_sel = 3'(i);
            @(negedge clk);
            vectors++;
            if (rd_ack !== 1'b1 || rd_data !== CW'(10 * (i + 1))) begin
                miscompares++;
                $display("FAIL basic_read ch%0d got ack=%b data=%0d exp ack=1 data=%0d", i, rd_ack, rd_data, 10 * (i + 1));
            end
        end
        rd_req = 1'b0;
        wait_done(seen);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            do_read(i, ack, data);
            want = (CLR != 0) ? CW'(10 * (i + 1)) : '0;
            vectors++;
            if (!seen || ack !== 1'b1 || data !== want) begin
                miscompares++;
                $display("FAIL basic_second_snapshot ch%0d seen=%b got ack=%b data=%0d exp ack=1 data=%0d", i, seen, ack, data, want);
            end
        end
    endtask

    task automatic test_wrap();
        bit s1, s2, s3, s4;
        logic ack;
        logic [CW-1:0] data;
        logic [CW-1:0] want;
        period = PW'(10);
        set_count(2, 'h7FF0);
        wait_done(s1);
        wait_done(s2);
        set_count(2, 'h0010);
        wait_done(s3);
        @(negedge clk);
        do_read(2, ack, data);
        want = (CLR != 0) ? CW'('h0010) : CW'('h0020);
        vectors++;
        if (!(s1 && s2 && s3) || ack !== 1'b1 || data !== want) begin
            miscompares++;
            $display("FAIL wrap_up got ack=%b data=%h exp ack=1 data=%h", ack, data, want);
        end
        set_count(2, 'h7FF0);
        wait_done(s4);
        @(negedge clk);
        do_read(2, ack, data);
        want = (CLR != 0) ? CW'('h7FF0) : CW'('h7FE0);
        vectors++;
        if (!s4 || ack !== 1'b1 || data !== want) begin
            miscompares++;
            $display("FAIL wrap_down got ack=%b data=%h exp ack=1 data=%h", ack, data, want);
        end
    endtask

    task automatic test_overrun();
        int last, exp_gap, ovr_cycles;
        bit saw_ovr;
        period  = PW'(4);
        exp_gap = 4 * ((N + 2 + 3) / 4);
        do_reset();
        last = -1; saw_ovr = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            ovr_clr = (($urandom % 4) == 0);
            @(negedge clk);
            vectors++;
            if ({sample_done, overrun, rd_ack, rd_data, cnt_clr} !== {exp_done, exp_ovr, exp_ack, exp_data, exp_clr}) begin
                miscompares++;
                $display("FAIL overrun_cycle n=%0d got done=%b ovr=%b clr=%b exp done=%b ovr=%b clr=%b",
                         n, sample_done, overrun, cnt_clr, exp_done, exp_ovr, exp_clr);
            end
            if (overrun === 1'b1) saw_ovr = 1'b1;
            if (sample_done === 1'b1) begin
                if (last >= 0) begin
                    vectors++;
                    if (n - last != exp_gap) begin
                        miscompares++;
                        $display("FAIL overrun_gap got %0d cycles exp %0d", n - last, exp_gap);
                    end
                end
                last = n;
            end
        end
        vectors++;
        if (!saw_ovr) begin
            miscompares++;
            $display("FAIL overrun_set got overrun never 1 exp 1");
        end
        ovr_clr = 1'b1;
        ovr_cycles = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            vectors++;
            if (overrun !== exp_ovr) begin
                miscompares++;
                $display("FAIL overrun_priority_cycle got %b exp %b", overrun, exp_ovr);
            end
            if (overrun === 1'b1) ovr_cycles++;
        end
        ovr_clr = 1'b0;
        vectors++;
        if (ovr_cycles == 0 || ovr_cycles == 16) begin
            miscompares++;
            $display("FAIL overrun_priority got %0d of 16 cycles set exp between 1 and 15", ovr_cycles);
        end
    endtask

    task automatic test_read_commit();
        bit s1, s2;
        logic ack;
        logic [CW-1:0] data;
        logic [CW-1:0] old_val;
        logic [CW-1:0] new_val;
        period = PW'(10);
        wait_done(s1);
        counts[CW +: CW] = counts[CW +: CW] + CW'('h123);
        wait_done(s2);
        old_val = m_front[1];
        new_val = m_back[1];
        do_read(1, ack, data);
        vectors++;
        if (!(s1 && s2) || ack !== 1'b1 || data !== old_val) begin
            miscompares++;
            $display("FAIL commit_read got ack=%b data=%h exp ack=1 data=%h", ack, data, old_val);
        end
        do_read(6, ack, data);
        vectors++;
        if (ack !== 1'b1 || data !== '0) begin
            miscompares++;
            $display("FAIL bad_sel_read got ack=%b data=%h exp ack=1 data=0", ack, data);
        end
        @(negedge clk);
        vectors++;
        if (rd_ack !== 1'b0 || rd_data !== '0) begin
            miscompares++;
            $display("FAIL read_hold got ack=%b data=%h exp ack=0 data=0", rd_ack, rd_data);
        end
        do_read(1, ack, data);
        vectors++;
        if (ack !== 1'b1 || data !== new_val) begin
            miscompares++;
            $display("FAIL post_commit_read got ack=%b data=%h exp ack=1 data=%h", ack, data, new_val);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        logic ack;
        logic [CW-1:0] data;
        period = PW'(10);
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (m_phase == 3) begin
                found = 1'b1;
                break;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (!found || {sample_done, overrun, rd_ack, rd_data, cnt_clr} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_sweep found=%b got done=%b ovr=%b ack=%b data=%h clr=%b exp all 0",
                     found, sample_done, overrun, rd_ack, rd_data, cnt_clr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            do_read(i, ack, data);
            vectors++;
            if (ack !== 1'b1 || data !== '0) begin
                miscompares++;
                $display("FAIL reset_front ch%0d got ack=%b data=%h exp ack=1 data=0", i, ack, data);
            end
        end
    endtask

    task automatic test_random();
        int plist[6] = '{0, 3, 4, 8, 13, 25};
        do_reset();
        for (int n = 0; n < 900; n++) begin
            if (n % 150 == 0) period = PW'(plist[$urandom % 6]);
            for (int ch = 0; ch < N; ch++) counts[ch*CW +: CW] = CW'($urandom);
            rd_req  = $urandom_range(0, 1) == 1;
            rd_sel  = 3'($urandom_range(0, 7));
            ovr_clr = ($urandom % 8) == 0;
            @(negedge clk);
            vectors++;
            if ({sample_done, overrun, rd_ack, rd_data, cnt_clr} !== {exp_done, exp_ovr, exp_ack, exp_data, exp_clr}) begin
                miscompares++;
                $display("FAIL random_cycle n=%0d got done=%b ovr=%b ack=%b data=%h clr=%b exp done=%b ovr=%b ack=%b data=%h clr=%b",
                         n, sample_done, overrun, rd_ack, rd_data, cnt_clr, exp_done, exp_ovr, exp_ack, exp_data, exp_clr);
            end
        end
        rd_req = 1'b0; ovr_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overrun();
        test_read_commit();
        test_reset_mid_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
